// File: rtl/pwm_capture_if.sv
// Signal bundle between the PWM capture block and the logic that reads its measurements.
// The slave side is the capture block; the master side drives the pin and reads results.
interface pwm_capture_if #(
  parameter int COUNTER_WIDTH = 11
);
  logic                     pwm_i;
  logic [COUNTER_WIDTH-1:0] period_cnt_o;
  logic [COUNTER_WIDTH-1:0] high_cnt_o;
  logic                     valid_o;
  logic                     stuck_o;
  logic                     stuck_level_o;

  modport slave (
    input  pwm_i,
    output period_cnt_o,
    output high_cnt_o,
    output valid_o,
    output stuck_o,
    output stuck_level_o
  );

  modport master (
    output pwm_i,
    input  period_cnt_o,
    input  high_cnt_o,
    input  valid_o,
    input  stuck_o,
    input  stuck_level_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an external PWM line and measures period and high time per cycle.
// Flags a line that shows no rising edge for a full counter range as stuck.
module pwm_capture #(
  parameter int COUNTER_WIDTH = 11,
  parameter int SYNC_STAGES   = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic [SYNC_STAGES-1:0]   sync_r;
  logic                     pwm_s;
  logic                     pwm_q_r;
  logic                     rise_r;
  logic                     fall_r;
  logic [1:0]               state_r;
  logic [COUNTER_WIDTH-1:0] cnt_p_r;
  logic [COUNTER_WIDTH-1:0] cnt_h_r;
  logic [COUNTER_WIDTH-1:0] period_r;
  logic [COUNTER_WIDTH-1:0] high_r;
  logic                     valid_r;
  logic                     stuck_r;
  logic                     stuck_level_r;

  assign pwm_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain plus registered edge detect; pwm_q_r is the level aligned with rise_r/fall_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      pwm_q_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.pwm_i};
      pwm_q_r <= pwm_s;
      rise_r  <= pwm_s & ~pwm_q_r;
      fall_r  <= ~pwm_s & pwm_q_r;
    end
  end

  // Measurement FSM: counts period/high time, publishes on each rise, detects a stuck line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_p_r       <= CNT_ZERO;
      cnt_h_r       <= CNT_ZERO;
      period_r      <= CNT_ZERO;
      high_r        <= CNT_ZERO;
      valid_r       <= 1'b0;
      stuck_r       <= 1'b0;
      stuck_level_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (rise_r) begin
        // A rise always wins, even on the cycle the period counter hits its ceiling.
        if ((state_r == ST_HIGH) || (state_r == ST_LOW)) begin
          period_r <= cnt_p_r;
          high_r   <= cnt_h_r;
          valid_r  <= 1'b1;
        end else begin
          period_r <= period_r;
          high_r   <= high_r;
        end
        cnt_p_r       <= CNT_ONE;
        cnt_h_r       <= CNT_ONE;
        stuck_r       <= 1'b0;
        stuck_level_r <= 1'b0;
        state_r       <= ST_HIGH;
      end else if (state_r == ST_STUCK) begin
        stuck_level_r <= pwm_q_r;
      end else if (cnt_p_r == CNT_MAX) begin
        state_r       <= ST_STUCK;
        stuck_r       <= 1'b1;
        stuck_level_r <= pwm_q_r;
      end else begin
        cnt_p_r <= sat_inc(cnt_p_r);
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_HIGH: begin
            if (fall_r) begin
              state_r <= ST_LOW;
            end else begin
              cnt_h_r <= sat_inc(cnt_h_r);
            end
          end
          ST_LOW:  state_r <= ST_LOW;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.period_cnt_o  = period_r;
  assign bus.high_cnt_o    = high_r;
  assign bus.valid_o       = valid_r;
  assign bus.stuck_o       = stuck_r;
  assign bus.stuck_level_o = stuck_level_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed waveforms plus random periods, compared every
// cycle against an edge-indexed reference model of the pin samples.
module tb_pwm_capture;

  localparam int CW   = 11;
  localparam int SS   = 2;
  localparam int MAXV = (1 << CW) - 1;
  localparam int LAT  = SS + 1;
  localparam int HW   = 16384;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.COUNTER_WIDTH(CW)) bus ();

  pwm_capture #(.COUNTER_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, indexed by clock edge number
  int   n         = 0;
  int   rst_edge  = 0;
  int   last_rise = -1;
  int   hi_acc    = 0;
  int   g_edge    = 0;
  logic prev_p    = 1'b0;
  logic smp [HW];
  int   ev_edge [$];
  int   ev_per  [$];
  int   ev_hi   [$];
  bit   ev_has  [$];
  bit   m_stuck = 1'b0;
  logic [CW-1:0] e_per = '0;
  logic [CW-1:0] e_hi  = '0;
  logic e_valid = 1'b0;
  logic e_stuck = 1'b0;
  logic e_lvl   = 1'b0;

  function automatic logic lvl_at(input int k);
    if (k <= rst_edge) return 1'b0;
    return smp[k % HW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // Advance the model by one clock edge given the pin value and reset sampled on that edge.
  task automatic model_edge(input logic pin, input logic rst_v);
    int per, hi, pe;
    bit has;
    n++;
    if (rst_v) begin
      rst_edge  = n;
      last_rise = -1;
      hi_acc    = 0;
      prev_p    = 1'b0;
      g_edge    = n + 1;
      ev_edge.delete(); ev_per.delete(); ev_hi.delete(); ev_has.delete();
      m_stuck = 1'b0;
      e_per = '0; e_hi = '0; e_valid = 1'b0; e_stuck = 1'b0; e_lvl = 1'b0;
    end else begin
      smp[n % HW] = pin;
      if (pin && !prev_p) begin
        ev_edge.push_back(n + LAT);
        ev_per.push_back(n - last_rise);
        ev_hi.push_back(hi_acc);
        ev_has.push_back(last_rise >= 0);
        last_rise = n;
        hi_acc    = 0;
      end
      if (pin) hi_acc++;
      prev_p  = pin;
      e_valid = 1'b0;
      if (ev_edge.size() > 0 && ev_edge[0] == n) begin
        pe  = ev_edge.pop_front();
        per = ev_per.pop_front();
        hi  = ev_hi.pop_front();
        has = ev_has.pop_front();
        if (m_stuck) begin
          m_stuck = 1'b0;
          e_lvl   = 1'b0;
        end else if (has) begin
          e_per   = per[CW-1:0];
          e_hi    = hi[CW-1:0];
          e_valid = 1'b1;
        end
        g_edge = pe;
      end else if (m_stuck) begin
        e_lvl = lvl_at(n - LAT);
      end else if (n - g_edge >= MAXV) begin
        m_stuck = 1'b1;
        e_lvl   = lvl_at(n - LAT);
      end
      e_stuck = m_stuck;
    end
  endtask

  task automatic step(input logic pin, input logic rst_v);
    bus.pwm_i = pin;
    rst       = rst_v;
    @(posedge clk);
    model_edge(pin, rst_v);
    #1;
    chk("valid",       32'(bus.valid_o),       32'(e_valid));
    chk("stuck",       32'(bus.stuck_o),       32'(e_stuck));
    chk("stuck_level", 32'(bus.stuck_level_o), 32'(e_lvl));
    chk("period",      32'(bus.period_cnt_o),  32'(e_per));
    chk("high",        32'(bus.high_cnt_o),    32'(e_hi));
  endtask

  task automatic wave(input int hi, input int lo, input int periods);
    for (int k = 0; k < periods; k++) begin
      for (int j = 0; j < hi; j++) step(1'b1, 1'b0);
      for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.pwm_i = 1'b0;
    rst       = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Line held low from reset
    repeat (MAXV + 20) step(1'b0, 1'b0);
    chk("idle_stuck",  32'(bus.stuck_o),       32'd1);
    chk("idle_level",  32'(bus.stuck_level_o), 32'd0);
    chk("idle_period", 32'(bus.period_cnt_o),  32'd0);

    // 3 high / 7 low
    wave(3, 7, 6);
    chk("w37_period", 32'(bus.period_cnt_o), 32'd10);
    chk("w37_high",   32'(bus.high_cnt_o),   32'd3);

    // Duty switch at a period boundary
    wave(5, 5, 4);
    chk("w55_high", 32'(bus.high_cnt_o), 32'd5);
    wave(8, 2, 4);
    chk("w82_high", 32'(bus.high_cnt_o), 32'd8);

    // Stuck high, then recovery
    wave(4, 6, 4);
    repeat (MAXV + 20) step(1'b1, 1'b0);
    chk("hold_stuck",  32'(bus.stuck_o),       32'd1);
    chk("hold_level",  32'(bus.stuck_level_o), 32'd1);
    chk("hold_period", 32'(bus.period_cnt_o),  32'd10);
    chk("hold_high",   32'(bus.high_cnt_o),    32'd4);
    wave(4, 6, 3);
    chk("resume_stuck", 32'(bus.stuck_o),    32'd0);
    chk("resume_high",  32'(bus.high_cnt_o), 32'd4);

    // Reset in the middle of a high phase
    wave(2, 8, 3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_period", 32'(bus.period_cnt_o), 32'd0);
    chk("rst_valid",  32'(bus.valid_o),      32'd0);
    repeat (8) step(1'b0, 1'b0);
    wave(2, 8, 3);
    chk("w28_high", 32'(bus.high_cnt_o), 32'd2);

    // Minimum legal waveform
    wave(1, 1, 20);
    chk("w11_period", 32'(bus.period_cnt_o), 32'd2);
    chk("w11_stuck",  32'(bus.stuck_o),      32'd0);

    // Period of exactly MAX publishes; one cycle longer goes stuck first
    step(1'b1, 1'b0);
    repeat (MAXV - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (LAT) step(1'b0, 1'b0);
    chk("max_valid",  32'(bus.valid_o),      32'd1);
    chk("max_period", 32'(bus.period_cnt_o), 32'(MAXV));
    repeat (MAXV) step(1'b0, 1'b0);
    wave(1, 1, 3);

    // Random periods
    for (int k = 0; k < 30; k++) begin
      wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 1);
    end
    repeat (6) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
